// File: rtl/processor_pkg.sv
// processor_pkg: shared opcode encodings, sizes and helpers for the processor slice.
package processor_pkg;
  localparam int IMEM_DEPTH = 32;
  localparam int NREGS = 8;
  typedef enum logic [3:0] {NOP = 4'h0, IRMOVL = 4'h1, OPL = 4'h2} icode_t;
  typedef enum logic [3:0] {ADD = 4'h0, SUB = 4'h1, AND = 4'h2, XOR = 4'h3} alu_fn_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/processor_if.sv
// processor_if: instruction-load and register-readback bus of the processor.
interface processor_if;
  logic [31:0] addr;
  logic wr;
  logic [31:0] wdata;
  logic working;
  logic [3:0] rID;
  logic [31:0] rdata;
  modport master(output addr, wr, wdata, working, rID, input rdata);
  modport slave(input addr, wr, wdata, working, rID, output rdata);
endinterface

// File: rtl/processor_alu.sv
// processor_alu: 32-bit add/sub/and/xor with ZF/SF, plus OF when PROC_OF_FLAG_EN is defined.
module processor_alu
  import processor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ifun,
  output logic [31:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of
);
  assign result = ifun == ADD ? a + b : ifun == SUB ? a - b : ifun == AND ? a & b : a ^ b;
  assign zf = result == 32'd0;
  assign sf = result[31];
`ifdef PROC_OF_FLAG_EN
  // a - b overflows when the operand signs differ and the result sign leaves a's
  assign of = ifun == ADD ? (a[31] == b[31]) && (result[31] != a[31]) :
              ifun == SUB ? (a[31] != b[31]) && (result[31] != a[31]) : 1'b0;
`else
  assign of = 1'b0;
`endif
endmodule

// File: rtl/processor.sv
// processor: single-cycle Y86-style core (irmovl/OPl) with loadable 32-word imem.
// Overflow flag cc[0] is built only when PROC_OF_FLAG_EN is defined.
module processor
  import processor_pkg::*;
(
  input  logic        clock,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        working,
  input  logic [3:0]  rID,
  output logic [31:0] valE,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r6,
  output logic [31:0] r7,
  output logic [31:0] rdata,
  output logic [2:0]  cc,
  input  logic        reset_n
);
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] regs [NREGS];
  logic [4:0]  pc;
  logic [31:0] ins, opa, opb, res, imm;
  logic [3:0]  icode, ifun, ra, rb;
  logic        zf, sf, of, is_irmovl, is_opl;
  logic        unused_addr;
  assign ins = imem[pc];
  assign icode = ins[31:28];
  assign ifun = ins[27:24];
  assign ra = ins[23:20];
  assign rb = ins[19:16];
  assign imm = sext16(ins[15:0]);
  // indices 8..15 name no register: they read as zero and are never written
  assign opa = ra[3] ? 32'd0 : regs[ra[2:0]];
  assign opb = rb[3] ? 32'd0 : regs[rb[2:0]];
  assign is_irmovl = icode == IRMOVL && ifun == 4'h0;
  assign is_opl = icode == OPL && ifun[3:2] == 2'b00;
  assign unused_addr = ^addr[31:5];
  processor_alu u_alu (.a(opb), .b(opa), .ifun(ifun), .result(res), .zf(zf), .sf(sf), .of(of));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc <= '0;
      valE <= '0;
      cc <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (working) begin
      pc <= pc + 5'd1;
      if (is_irmovl) begin
        valE <= imm;
        if (!rb[3]) regs[rb[2:0]] <= imm;
      end else if (is_opl) begin
        valE <= res;
        cc <= {zf, sf, of};
        if (!rb[3]) regs[rb[2:0]] <= res;
      end
    end else begin
      pc <= '0;
      if (wr) imem[addr[4:0]] <= wdata;
    end
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];
  assign rdata = rID[3] ? 32'd0 : regs[rID[2:0]];
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed self-checking bench for processor.
module tb_processor;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] valE;
  logic [31:0] r [8];
  logic [2:0] cc;
  int checks = 0;
  int errors = 0;
`ifdef PROC_OF_FLAG_EN
  localparam logic OF_EN = 1'b1;
`else
  localparam logic OF_EN = 1'b0;
`endif
  logic [31:0] prog_exp [8] = '{32'h80, 32'h101, 32'h82, 32'h1, 32'h84, 32'h84, 32'h86, 32'h1};

  processor_if bus();

  processor dut (
    .clock(clock), .addr(bus.addr), .wr(bus.wr), .wdata(bus.wdata), .working(bus.working),
    .rID(bus.rID), .valE(valE), .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]), .r4(r[4]),
    .r5(r[5]), .r6(r[6]), .r7(r[7]), .rdata(bus.rdata), .cc(cc), .reset_n(reset_n)
  );

  always #5 clock = ~clock;

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    bus.working = 1'b0;
    bus.addr = {27'd0, a};
    bus.wdata = d;
    bus.wr = 1'b1;
    @(posedge clock);
    #1;
    bus.wr = 1'b0;
  endtask

  task automatic run(input int n);
    bus.working = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic stop();
    bus.working = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 32'd0) begin errors++; $display("FAIL reset_r%0d got %h exp 0", i, r[i]); end
    end
    checks++;
    if (valE !== 32'd0) begin errors++; $display("FAIL reset_valE got %h exp 0", valE); end
    checks++;
    if (cc !== 3'b000) begin errors++; $display("FAIL reset_cc got %b exp 000", cc); end
    checks++;
    if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_program();
    for (int i = 0; i < 8; i++) load(5'(i), 32'h10F00080 | (i << 16) | i);
    load(5'd8, 32'h20010000);
    load(5'd9, 32'h11000000);
    load(5'd10, 32'h21230000);
    load(5'd11, 32'h12000000);
    load(5'd12, 32'h22450000);
    load(5'd13, 32'h11000000);
    load(5'd14, 32'h23670000);
    run(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 32'h80 + i) begin errors++; $display("FAIL irmovl_r%0d got %h exp %h", i, r[i], 32'h80 + i); end
    end
    checks++;
    if (valE !== 32'h87) begin errors++; $display("FAIL irmovl_valE got %h exp 87", valE); end
    run(7);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== prog_exp[i]) begin errors++; $display("FAIL opl_r%0d got %h exp %h", i, r[i], prog_exp[i]); end
    end
    checks++;
    if (valE !== 32'h1) begin errors++; $display("FAIL opl_valE got %h exp 1", valE); end
    checks++;
    if (cc !== 3'b000) begin errors++; $display("FAIL opl_cc got %b exp 000", cc); end
    stop();
  endtask

  task automatic test_readback();
    for (int i = 0; i < 16; i++) begin
      bus.rID = 4'(i);
      #1;
      checks++;
      if (bus.rdata !== (i < 8 ? prog_exp[i] : 32'd0)) begin
        errors++;
        $display("FAIL readback_%0d got %h exp %h", i, bus.rdata, i < 8 ? prog_exp[i] : 32'd0);
      end
    end
    bus.rID = 4'd0;
  endtask

  task automatic test_sub_zero();
    load(5'd0, 32'h10F20005);
    load(5'd1, 32'h10F30005);
    load(5'd2, 32'h21230000);
    run(3);
    checks++;
    if (r[3] !== 32'd0) begin errors++; $display("FAIL subzero_r3 got %h exp 0", r[3]); end
    checks++;
    if (valE !== 32'd0) begin errors++; $display("FAIL subzero_valE got %h exp 0", valE); end
    checks++;
    if (cc !== 3'b100) begin errors++; $display("FAIL subzero_cc got %b exp 100", cc); end
    stop();
  endtask

  task automatic test_overflow();
    load(5'd0, 32'h10F38000);
    for (int i = 1; i <= 16; i++) load(5'(i), 32'h20330000);
    load(5'd17, 32'h10F20001);
    load(5'd18, 32'h21230000);
    load(5'd19, 32'h20230000);
    run(1);
    checks++;
    if (r[3] !== 32'hFFFF8000) begin errors++; $display("FAIL sext_r3 got %h exp ffff8000", r[3]); end
    checks++;
    if (cc !== 3'b100) begin errors++; $display("FAIL irmovl_keeps_cc got %b exp 100", cc); end
    run(16);
    checks++;
    if (r[3] !== 32'h80000000) begin errors++; $display("FAIL double_r3 got %h exp 80000000", r[3]); end
    checks++;
    if (cc !== 3'b010) begin errors++; $display("FAIL double_cc got %b exp 010", cc); end
    run(2);
    checks++;
    if (r[3] !== 32'h7FFFFFFF) begin errors++; $display("FAIL subov_r3 got %h exp 7fffffff", r[3]); end
    checks++;
    if (cc !== {2'b00, OF_EN}) begin errors++; $display("FAIL subov_cc got %b exp %b", cc, {2'b00, OF_EN}); end
    run(1);
    checks++;
    if (r[3] !== 32'h80000000) begin errors++; $display("FAIL addov_r3 got %h exp 80000000", r[3]); end
    checks++;
    if (cc !== {2'b01, OF_EN}) begin errors++; $display("FAIL addov_cc got %b exp %b", cc, {2'b01, OF_EN}); end
    stop();
  endtask

  task automatic test_high_index();
    load(5'd0, 32'h10F80055);
    load(5'd1, 32'h10F10007);
    load(5'd2, 32'h20810000);
    load(5'd3, 32'h24120000);
    load(5'd4, 32'h30120000);
    run(1);
    checks++;
    if (valE !== 32'h55) begin errors++; $display("FAIL rb8_valE got %h exp 55", valE); end
    checks++;
    if (r[0] !== 32'h80) begin errors++; $display("FAIL rb8_r0 got %h exp 80", r[0]); end
    run(2);
    checks++;
    if (r[1] !== 32'h7) begin errors++; $display("FAIL ra8_r1 got %h exp 7", r[1]); end
    checks++;
    if (cc !== 3'b000) begin errors++; $display("FAIL ra8_cc got %b exp 000", cc); end
    run(2);
    checks++;
    if (r[2] !== 32'h1) begin errors++; $display("FAIL nop_r2 got %h exp 1", r[2]); end
    checks++;
    if (valE !== 32'h7) begin errors++; $display("FAIL nop_valE got %h exp 7", valE); end
    stop();
  endtask

  task automatic test_wr_ignored();
    load(5'd0, 32'h10F10011);
    load(5'd1, 32'h00000000);
    bus.working = 1'b1;
    bus.addr = 32'd0;
    bus.wdata = 32'h10F10022;
    bus.wr = 1'b1;
    run(2);
    bus.wr = 1'b0;
    checks++;
    if (r[1] !== 32'h11) begin errors++; $display("FAIL wrrun_r1 got %h exp 11", r[1]); end
    stop();
    run(1);
    checks++;
    if (r[1] !== 32'h11) begin errors++; $display("FAIL wrrerun_r1 got %h exp 11", r[1]); end
    stop();
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 8; i++) load(5'(i), 32'h10F00080 | (i << 16) | i);
    run(3);
    reset_n = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 32'd0) begin errors++; $display("FAIL arst_r%0d got %h exp 0", i, r[i]); end
    end
    checks++;
    if (valE !== 32'd0) begin errors++; $display("FAIL arst_valE got %h exp 0", valE); end
    checks++;
    if (cc !== 3'b000) begin errors++; $display("FAIL arst_cc got %b exp 000", cc); end
    bus.working = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== 32'd0) begin errors++; $display("FAIL empty_r%0d got %h exp 0", i, r[i]); end
    end
    checks++;
    if (valE !== 32'd0) begin errors++; $display("FAIL empty_valE got %h exp 0", valE); end
    stop();
  endtask

  initial begin
    bus.addr = 32'd0;
    bus.wr = 1'b0;
    bus.wdata = 32'd0;
    bus.working = 1'b0;
    bus.rID = 4'd0;
    test_reset();
    test_program();
    test_readback();
    test_sub_zero();
    test_overflow();
    test_high_index();
    test_wr_ignored();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 The clock port SHALL be `clock`, an input of width 1; all state SHALL update on its rising edge.
REQ-002 The reset port SHALL be `reset_n`, an input of width 1, asynchronous and active-low, and SHALL be the last port.
REQ-003 `addr` SHALL be a 32-bit input giving the instruction-memory write address; only bits [4:0] are used.
REQ-004 `wr` SHALL be a 1-bit input that enables an instruction-memory write.
REQ-005 `wdata` SHALL be a 32-bit input carrying the instruction word to write.
REQ-006 `working` SHALL be a 1-bit input; 1 selects run mode and 0 selects load/idle mode.
REQ-007 `rID` SHALL be a 4-bit input giving the register-file readback index.
REQ-008 `valE` SHALL be a 32-bit output holding the result of the last executed instruction.
REQ-009 `r0` through `r7` SHALL each be a 32-bit output showing the live contents of one register.
REQ-010 `rdata` SHALL be a 32-bit output carrying the readback register value.
REQ-011 `cc` SHALL be a 3-bit output of condition codes: bit 2 ZF, bit 1 SF, bit 0 OF.
REQ-012 Port order SHALL be: clock, addr, wr, wdata, working, rID, valE, r0..r7, rdata, cc, reset_n.

Function
REQ-013 Instruction memory SHALL be 32 x 32-bit, addressed by addr[4:0].
REQ-014 When working=0 and wr=1, the design SHALL write wdata to imem[addr[4:0]] at the clock edge.
REQ-015 When working=1, writes SHALL be ignored.
REQ-016 The instruction format SHALL be: icode[31:28], ifun[27:24], rA[23:20], rB[19:16], valC[15:0].
REQ-017 The design SHALL be single-cycle: while working=1, each edge executes imem[PC] and sets PC to PC+1, wrapping from 31 to 0.
REQ-018 While working=0, PC SHALL be held at 0.
REQ-019 Instruction icode=1, ifun=0 (irmovl) SHALL perform R[rB] <= sign-extended valC and set valE to the same value; cc SHALL be unchanged and rA SHALL be ignored.
REQ-020 Instruction icode=2 (OPl) SHALL compute valE = R[rB] op R[rA] and write valE to R[rB].
REQ-021 OPl ifun codes SHALL be: 0 add; 1 sub (R[rB]-R[rA]); 2 and; 3 xor; 4-15 treated as NOP.
REQ-022 OPl SHALL update cc as follows: ZF = (valE==0); SF = valE[31].
REQ-023 OPl OF SHALL be two's-complement signed overflow for add and sub, and 0 for and and xor.
REQ-024 All other icodes, and icode=1 with ifun!=0, SHALL be NOPs that change no state except PC.
REQ-025 Register indices rA/rB of 8 or above SHALL read as 0 and SHALL never be written.
REQ-026 rdata SHALL equal R[rID] for rID 0-7 and 0 for rID 8-15; it is combinational and valid in either mode.
REQ-027 r0..r7 SHALL reflect register contents combinationally from the register outputs.
REQ-028 All arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-029 reset_n=0 SHALL asynchronously clear PC, all registers, valE, cc (to 3'b000) and all instruction-memory words to 0.
REQ-030 Reset mid-run SHALL abort execution; after release, the design SHALL restart from PC=0 once working=1.

Configuration
REQ-031 The design SHALL support a macro `PROC_OF_FLAG_EN`: when defined, cc[0] implements OF per REQ-023; when undefined, cc[0] is constant 0 and no overflow logic is built.

Structure
REQ-032 A shared package `processor_pkg` SHALL hold the icode constants (NOP, IRMOVL=1, OPL=2), the ALU ifun constants (ADD=0, SUB=1, AND=2, XOR=3), IMEM_DEPTH=32 and NREGS=8.
REQ-033 A sub-module `processor_alu` SHALL take operands a, b and ifun and return the result plus ZF/SF/OF.

Verification
REQ-034 Load imem[0..7] with irmovl words 10F00080..10F70087, run -> r0..r7 = 0x80..0x87.
REQ-035 Continue with 20010000 (add), 21230000 (sub), 22450000 (and), 23670000 (xor), with 11000000/12000000 NOPs between -> r1=0x101, r3=0x1, r5=0x84, r7=0x1, cc=3'b000 after the xor.
REQ-036 Run sub with equal operands (r2=r3=5, 21230000) -> r3=0, cc[2]=1; with r3=0x80000000 and r2=1 -> r3=0x7FFFFFFF, OF=1 when PROC_OF_FLAG_EN is defined.
REQ-037 After a run with working=0, sweep rID 0..15 -> rdata = r0..r7, then 0 for rID 8..15.
REQ-038 Apply wr=1 during working=1, then re-run -> imem is unchanged.
REQ-039 Pulse reset_n low mid-run -> all outputs are 0 immediately; a re-run from an empty imem leaves all registers at 0.
